// File: rtl/control_unit.sv
// control_unit: multicycle MIPS control FSM (fetch/decode/execute/mem/wb/exceptions)
// Ports: clk, reset (async, active-high); opcode/funct from IR; overflow/eq ALU flags;
// enables pcWrite..epcControl; mux selects iord, aluSrcA/B, srcWrite, srcData, pcSource;
// aluControl op; lsControl/ssControl size; excpControl cause vector; state for debug.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       eq,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       memRegControl,
  output logic       aControl,
  output logic       bControl,
  output logic       aluOutControl,
  output logic       epcControl,
  output logic [1:0] iord,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic [2:0] srcWrite,
  output logic [3:0] srcData,
  output logic [2:0] pcSource,
  output logic [1:0] lsControl,
  output logic [1:0] ssControl,
  output logic [1:0] excpControl,
  output logic [4:0] state
);
  typedef enum logic [4:0] {
    RESET, FETCH0, FETCH1, FETCH2, DECODE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB,
    MEM_ADDR, LW0, LW1, LW2, LW3, SW0, BRANCH, JUMP, EXC0, EXC1, EXC2, EXC3, EXC4
  } state_t;
  state_t cur, nxt;
  logic excCause, nxtCause;
  logic rAdd, rSub, rAnd;
  assign rAdd = funct == 6'h20;
  assign rSub = funct == 6'h22;
  assign rAnd = funct == 6'h24;
  assign state = cur;
  // cause is captured only on entry to EXC0 so it holds through the vector fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= RESET;
      excCause <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == EXC0) excCause <= nxtCause;
    end
  end
  always_comb begin
    nxt = cur;
    nxtCause = 1'b0;
    pcWrite = 1'b0;
    irWrite = 1'b0;
    regWrite = 1'b0;
    memWrite = 1'b0;
    memRegControl = 1'b0;
    aControl = 1'b0;
    bControl = 1'b0;
    aluOutControl = 1'b0;
    epcControl = 1'b0;
    iord = 2'd0;
    aluSrcA = 2'd0;
    aluSrcB = 2'd0;
    aluControl = 3'd0;
    srcWrite = 3'd0;
    srcData = 4'd0;
    pcSource = 3'd0;
    lsControl = 2'd0;
    ssControl = 2'd0;
    excpControl = 2'd0;
    case (cur)
      RESET: begin
        regWrite = 1'b1;
        srcWrite = 3'd2;
        srcData = 4'd8;
        nxt = FETCH0;
      end
      FETCH0: begin
        aluSrcB = 2'd1;
        aluControl = 3'b001;
        pcWrite = 1'b1;
        nxt = FETCH1;
      end
      FETCH1: nxt = FETCH2;
      FETCH2: begin
        irWrite = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        aControl = 1'b1;
        bControl = 1'b1;
        aluSrcB = 2'd3;
        aluControl = 3'b001;
        aluOutControl = 1'b1;
        case (opcode)
          6'h00: nxt = R_EXEC;
          6'h08: nxt = ADDI_EXEC;
          6'h23, 6'h2B: nxt = MEM_ADDR;
          6'h04, 6'h05: nxt = BRANCH;
          6'h02: nxt = JUMP;
          default: nxt = EXC0;
        endcase
      end
      R_EXEC: begin
        aluSrcA = 2'd1;
        aluOutControl = 1'b1;
        aluControl = rAdd ? 3'b001 : rSub ? 3'b010 : rAnd ? 3'b011 : 3'b000;
        nxtCause = rAdd | rSub;
        // and never overflows; unknown funct reports invalid instruction
        nxt = (!(rAdd | rSub | rAnd) || (overflow && !rAnd)) ? EXC0 : R_WB;
      end
      R_WB: begin
        regWrite = 1'b1;
        srcWrite = 3'd1;
        nxt = FETCH0;
      end
      ADDI_EXEC, MEM_ADDR: begin
        aluSrcA = 2'd1;
        aluSrcB = 2'd2;
        aluControl = 3'b001;
        aluOutControl = 1'b1;
        nxtCause = 1'b1;
        nxt = cur == MEM_ADDR ? (opcode == 6'h23 ? LW0 : SW0) : overflow ? EXC0 : ADDI_WB;
      end
      ADDI_WB: begin
        regWrite = 1'b1;
        nxt = FETCH0;
      end
      LW0: begin
        iord = 2'd1;
        nxt = LW1;
      end
      LW1: nxt = LW2;
      LW2: begin
        memRegControl = 1'b1;
        nxt = LW3;
      end
      LW3: begin
        regWrite = 1'b1;
        srcData = 4'd1;
        nxt = FETCH0;
      end
      SW0: begin
        iord = 2'd1;
        memWrite = 1'b1;
        nxt = FETCH0;
      end
      BRANCH: begin
        aluSrcA = 2'd1;
        aluControl = 3'b111;
        pcSource = 3'd1;
        pcWrite = opcode == 6'h04 ? eq : !eq;
        nxt = FETCH0;
      end
      JUMP: begin
        pcSource = 3'd2;
        pcWrite = 1'b1;
        nxt = FETCH0;
      end
      EXC0: begin
        aluSrcB = 2'd1;
        aluControl = 3'b010;
        epcControl = 1'b1;
        nxt = EXC1;
      end
      EXC1: begin
        iord = 2'd2;
        excpControl = {1'b0, excCause};
        nxt = EXC2;
      end
      EXC2: nxt = EXC3;
      EXC3: begin
        memRegControl = 1'b1;
        nxt = EXC4;
      end
      EXC4: begin
        pcSource = 3'd5;
        lsControl = 2'd2;
        pcWrite = 1'b1;
        nxt = FETCH0;
      end
      default: nxt = RESET;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit with directed instruction sequences
module tb_control_unit;
  typedef struct packed {
    logic [4:0] st;
    logic pcW, irW, regW, memW, memReg, aC, bC, aluOut, epc;
    logic [1:0] iord, srcA, srcB;
    logic [2:0] aluCtl, srcW;
    logic [3:0] srcD;
    logic [2:0] pcSrc;
    logic [1:0] ls, ss, excp;
  } outs_t;
  localparam logic [4:0] S_RESET = 0, S_F0 = 1, S_F1 = 2, S_F2 = 3, S_DEC = 4, S_REX = 5,
    S_RWB = 6, S_AEX = 7, S_AWB = 8, S_MA = 9, S_LW0 = 10, S_LW1 = 11, S_LW2 = 12, S_LW3 = 13,
    S_SW0 = 14, S_BR = 15, S_J = 16, S_E0 = 17, S_E1 = 18, S_E2 = 19, S_E3 = 20, S_E4 = 21;
  logic clk = 0, reset = 1, overflow = 0, eq = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic pcWrite, irWrite, regWrite, memWrite, memRegControl, aControl, bControl, aluOutControl, epcControl;
  logic [1:0] iord, aluSrcA, aluSrcB, lsControl, ssControl, excpControl;
  logic [2:0] aluControl, srcWrite, pcSource;
  logic [3:0] srcData;
  logic [4:0] state;
  outs_t act;
  outs_t expQ[$];
  string nameQ[$];
  int tests = 0, fails = 0;
  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .overflow(overflow), .eq(eq),
    .pcWrite(pcWrite), .irWrite(irWrite), .regWrite(regWrite), .memWrite(memWrite),
    .memRegControl(memRegControl), .aControl(aControl), .bControl(bControl),
    .aluOutControl(aluOutControl), .epcControl(epcControl), .iord(iord), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .srcWrite(srcWrite), .srcData(srcData),
    .pcSource(pcSource), .lsControl(lsControl), .ssControl(ssControl),
    .excpControl(excpControl), .state(state)
  );
  assign act = {state, pcWrite, irWrite, regWrite, memWrite, memRegControl, aControl, bControl,
                aluOutControl, epcControl, iord, aluSrcA, aluSrcB, aluControl, srcWrite, srcData,
                pcSource, lsControl, ssControl, excpControl};
  always #5 clk = ~clk;
  // expected outputs per state, straight from the state table; a = ALU op or cause, pw = branch write
  function automatic outs_t ex(input logic [4:0] s, input logic [2:0] a = 0, input logic pw = 0);
    outs_t e;
    e = '0;
    e.st = s;
    case (s)
      S_RESET: begin e.regW = 1; e.srcW = 2; e.srcD = 8; end
      S_F0: begin e.pcW = 1; e.srcB = 1; e.aluCtl = 3'b001; end
      S_F2: e.irW = 1;
      S_DEC: begin e.aC = 1; e.bC = 1; e.srcB = 3; e.aluCtl = 3'b001; e.aluOut = 1; end
      S_REX: begin e.srcA = 1; e.aluCtl = a; e.aluOut = 1; end
      S_RWB: begin e.regW = 1; e.srcW = 1; end
      S_AEX, S_MA: begin e.srcA = 1; e.srcB = 2; e.aluCtl = 3'b001; e.aluOut = 1; end
      S_AWB: e.regW = 1;
      S_LW0: e.iord = 1;
      S_LW2: e.memReg = 1;
      S_LW3: begin e.regW = 1; e.srcD = 1; end
      S_SW0: begin e.iord = 1; e.memW = 1; end
      S_BR: begin e.srcA = 1; e.aluCtl = 3'b111; e.pcSrc = 1; e.pcW = pw; end
      S_J: begin e.pcSrc = 2; e.pcW = 1; end
      S_E0: begin e.srcB = 1; e.aluCtl = 3'b010; e.epc = 1; end
      S_E1: begin e.iord = 2; e.excp = a[1:0]; end
      S_E3: e.memReg = 1;
      S_E4: begin e.pcSrc = 5; e.ls = 2; e.pcW = 1; end
      default: ;
    endcase
    return e;
  endfunction
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      outs_t e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", n, act, act.st, e, e.st);
      end
    end
  end
  task automatic cyc(input string n, input outs_t e);
    expQ.push_back(e);
    nameQ.push_back(n);
    @(posedge clk);
    #1;
  endtask
  task automatic fetchDec(input string n, input logic [5:0] op, input logic [5:0] fn,
                          input logic ov, input logic q);
    opcode = op;
    funct = fn;
    overflow = ov;
    eq = q;
    cyc({n, " F0"}, ex(S_F0));
    cyc({n, " F1"}, ex(S_F1));
    cyc({n, " F2"}, ex(S_F2));
    cyc({n, " DEC"}, ex(S_DEC));
  endtask
  task automatic exc(input string n, input logic [2:0] cause);
    cyc({n, " E0"}, ex(S_E0));
    cyc({n, " E1"}, ex(S_E1, cause));
    cyc({n, " E2"}, ex(S_E2));
    cyc({n, " E3"}, ex(S_E3));
    cyc({n, " E4"}, ex(S_E4));
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc("reset held", ex(S_RESET));
    reset = 0;
    cyc("reset released", ex(S_RESET));
    fetchDec("add", 6'h00, 6'h20, 0, 0);
    cyc("add REX", ex(S_REX, 3'b001));
    cyc("add RWB", ex(S_RWB));
    fetchDec("sub ovf", 6'h00, 6'h22, 1, 0);
    cyc("sub ovf REX", ex(S_REX, 3'b010));
    exc("sub ovf", 1);
    fetchDec("and ovf", 6'h00, 6'h24, 1, 0);
    cyc("and ovf REX", ex(S_REX, 3'b011));
    cyc("and ovf RWB", ex(S_RWB));
    fetchDec("bad funct", 6'h00, 6'h25, 0, 0);
    cyc("bad funct REX", ex(S_REX, 3'b000));
    exc("bad funct", 0);
    fetchDec("addi", 6'h08, 6'h00, 0, 0);
    cyc("addi AEX", ex(S_AEX));
    cyc("addi AWB", ex(S_AWB));
    fetchDec("addi ovf", 6'h08, 6'h00, 1, 0);
    cyc("addi ovf AEX", ex(S_AEX));
    exc("addi ovf", 1);
    fetchDec("lw", 6'h23, 6'h00, 0, 0);
    cyc("lw MA", ex(S_MA));
    cyc("lw LW0", ex(S_LW0));
    cyc("lw LW1", ex(S_LW1));
    cyc("lw LW2", ex(S_LW2));
    cyc("lw LW3", ex(S_LW3));
    fetchDec("sw", 6'h2B, 6'h00, 0, 0);
    cyc("sw MA", ex(S_MA));
    cyc("sw SW0", ex(S_SW0));
    fetchDec("beq taken", 6'h04, 6'h00, 0, 1);
    cyc("beq taken BR", ex(S_BR, 0, 1));
    fetchDec("beq not", 6'h04, 6'h00, 0, 0);
    cyc("beq not BR", ex(S_BR, 0, 0));
    fetchDec("bne taken", 6'h05, 6'h00, 0, 0);
    cyc("bne taken BR", ex(S_BR, 0, 1));
    fetchDec("bne not", 6'h05, 6'h00, 0, 1);
    cyc("bne not BR", ex(S_BR, 0, 0));
    fetchDec("j", 6'h02, 6'h00, 0, 0);
    cyc("j J", ex(S_J));
    fetchDec("op3F", 6'h3F, 6'h00, 0, 0);
    exc("op3F", 0);
    fetchDec("lw abort", 6'h23, 6'h00, 0, 0);
    cyc("lw abort MA", ex(S_MA));
    cyc("lw abort LW0", ex(S_LW0));
    reset = 1;
    cyc("async reset in LW1", ex(S_RESET));
    reset = 0;
    cyc("reset after abort", ex(S_RESET));
    fetchDec("j recover", 6'h02, 6'h00, 0, 0);
    cyc("j recover J", ex(S_J));
    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", expQ.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM that drives every control input of the `cpu_MIPS` datapath from the decoded instruction and ALU flags. It sits beside the datapath, takes opcode/funct and comparison/overflow flags, and issues per-cycle mux selects, register enables and memory strobes for fetch, decode, execute, memory, write-back and exception handling. Supported set: R-type add/sub/and, addi, lw, sw, beq, bne, j, plus overflow and invalid-instruction exceptions.

## Interface
- No parameters; all encodings are fixed below.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]. `funct` in 6: IR[5:0].
- `overflow`, `eq` in 1: ALU flags, combinational, same cycle.
- `pcWrite`, `irWrite`, `regWrite`, `memWrite`, `memRegControl`, `aControl`, `bControl`, `aluOutControl`, `epcControl` out 1: load enables and strobes.
- `iord` out 2: 0 = PC, 1 = ALUOut, 2 = exception vector, 3 = ALU result.
- `aluSrcA` out 2: 0 = PC, 1 = A, 2 = MDR. `aluSrcB` out 2: 0 = B, 1 = 4, 2 = sign-extended imm, 3 = imm<<2.
- `aluControl` out 3: 001 add, 010 sub, 011 and, 111 compare.
- `srcWrite` out 3: 0 = rt, 1 = rd, 2 = R29. `srcData` out 4: 0 = ALUOut, 1 = load data, 8 = constant 227.
- `pcSource` out 3: 0 = ALU result, 1 = ALUOut, 2 = jump concat, 5 = LS output.
- `lsControl`, `ssControl` out 2: 0 = word, 2 = byte. `excpControl` out 2: 0 = vector 253 (invalid), 1 = vector 254 (overflow).
- `state` out 5: current state, for debug and verification.

## Operation
- Unlisted outputs are 0 in each state. Outputs are decoded from state; `pcWrite` in branch states and exits from EXEC states also depend on flags.
- RESET: `regWrite`, `srcWrite`=2, `srcData`=8 (R29 <- 227) -> FETCH0.
- FETCH0: `iord`=0, `aluSrcA`=0, `aluSrcB`=1, add, `pcSource`=0, `pcWrite` (PC <- PC+4). FETCH1: memory wait. FETCH2: `irWrite`.
- DECODE: `aControl`, `bControl`, `aluSrcA`=0, `aluSrcB`=3, add, `aluOutControl` (branch target). Dispatch on opcode: 0x00 -> R_EXEC; 0x08 -> ADDI_EXEC; 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; any other -> EXC0 with cause 0.
- R_EXEC: `aluSrcA`=1, `aluSrcB`=0. funct 0x20 add, 0x22 sub, 0x24 and; `aluOutControl`. Other funct -> EXC0 cause 0. `overflow` on add/sub -> EXC0 cause 1, else -> R_WB. Overflow is ignored for and.
- R_WB: `regWrite`, `srcWrite`=1, `srcData`=0 -> FETCH0.
- ADDI_EXEC: `aluSrcA`=1, `aluSrcB`=2, add, `aluOutControl`. `overflow` -> EXC0 cause 1, else ADDI_WB (`regWrite`, `srcWrite`=0, `srcData`=0).
- MEM_ADDR: `aluSrcA`=1, `aluSrcB`=2, add, `aluOutControl`. lw -> LW0, sw -> SW0.
- LW0: `iord`=1. LW1: wait. LW2: `memRegControl`. LW3: `regWrite`, `srcWrite`=0, `srcData`=1, `lsControl`=0.
- SW0: `iord`=1, `memWrite`, `ssControl`=0 -> FETCH0.
- BRANCH: `aluSrcA`=1, `aluSrcB`=0, compare. `pcSource`=1. `pcWrite` = `eq` for beq or !`eq` for bne.
- JUMP: `pcSource`=2, `pcWrite`.
- EXC0: `aluSrcA`=0, `aluSrcB`=1, sub, `epcControl` (EPC <- PC-4). Cause is latched in an internal register.
- EXC1: `iord`=2, `excpControl`=cause. EXC2: wait. EXC3: `memRegControl`. EXC4: `pcSource`=5, `lsControl`=2, `pcWrite` -> FETCH0.

## Timing
- Reset is asynchronous. While `reset` is high: state = RESET, all outputs 0 except RESET decode (`regWrite`=1, `srcWrite`=2, `srcData`=8). The first rising edge after deassertion moves the FSM to FETCH0.
- Reset asserted mid-instruction or mid-exception aborts immediately. There is no partial write-back after reset.
- Memory read data is valid two edges after the address cycle. This gives one wait state (FETCH1, LW1, EXC2).
- Instruction latencies, counted from FETCH0: R/addi 6, lw 9, sw 6, beq/bne 5, j 5. An exception adds 5 cycles from EXC0.
- `regWrite` is never asserted in a cycle that can detect overflow. An overflowing instruction therefore never writes a register.

## Test plan
- Reset release -> first cycle asserts `regWrite`, `srcWrite`=2, `srcData`=8; next state FETCH0 with `pcWrite`=1, `aluSrcB`=1.
- opcode 0x00, funct 0x20, `overflow`=0 -> sequence FETCH0, FETCH1, FETCH2, DECODE, R_EXEC, R_WB; `regWrite`=1, `srcWrite`=1 only in R_WB.
- opcode 0x04, `eq`=1 -> `pcWrite`=1, `pcSource`=1 in BRANCH. With `eq`=0 -> `pcWrite`=0, then FETCH0.
- opcode 0x23 -> `iord`=1 in LW0, `memRegControl` in LW2, `regWrite`/`srcData`=1 in LW3; 9 cycles total.
- addi with `overflow`=1 -> EXC0 (`epcControl`=1), EXC1 `excpControl`=1, EXC4 `pcSource`=5 and `pcWrite`; no `regWrite` anywhere.
- opcode 0x3F -> EXC1 `excpControl`=0. `reset` pulsed during LW1 -> outputs go to RESET decode asynchronously with no `memWrite`.
